// File: rtl/voracity_pkg.sv
// voracity_pkg: shared types and helpers for the voracity byte parsers.
//   char_class_e : predicate class encoding used on the 'mode' input
//   tw_state_e   : byte_take_while FSM state encoding
//   SPACE_*      : the four bytes treated as whitespace
//   class_match(): combinational byte-vs-class predicate

package voracity_pkg;

    typedef enum logic [2:0] {
        CLS_ALPHA = 3'd0,
        CLS_DIGIT = 3'd1,
        CLS_ALNUM = 3'd2,
        CLS_HEX   = 3'd3,
        CLS_SPACE = 3'd4,
        CLS_RANGE = 3'd5,
        CLS_NONE6 = 3'd6,
        CLS_NONE7 = 3'd7
    } char_class_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } tw_state_e;

    localparam logic [7:0] SPACE_SP  = 8'h20;
    localparam logic [7:0] SPACE_TAB = 8'h09;
    localparam logic [7:0] SPACE_LF  = 8'h0A;
    localparam logic [7:0] SPACE_CR  = 8'h0D;

    // Range class with lo > hi is empty: both bounds must hold, so it
    // never matches without a special case.
    function automatic logic class_match(input char_class_e cls,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi,
                                         input logic [7:0] b);
        logic is_digit;
        logic is_upper;
        logic is_lower;
        logic is_hexl;
        logic result;
        is_digit = (b >= 8'h30) && (b <= 8'h39);
        is_upper = (b >= 8'h41) && (b <= 8'h5A);
        is_lower = (b >= 8'h61) && (b <= 8'h7A);
        is_hexl  = ((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66));
        case (cls)
            CLS_ALPHA: result = is_upper | is_lower;
            CLS_DIGIT: result = is_digit;
            CLS_ALNUM: result = is_upper | is_lower | is_digit;
            CLS_HEX:   result = is_digit | is_hexl;
            CLS_SPACE: result = (b == SPACE_SP) || (b == SPACE_TAB) ||
                                (b == SPACE_LF) || (b == SPACE_CR);
            CLS_RANGE: result = (b >= lo) && (b <= hi);
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/char_class_match.sv
// char_class_match: combinational character-class predicate.
// Ports:
//   data   in  8  byte under test
//   cls    in  3  class (char_class_e encoding)
//   lo/hi  in  8  inclusive bounds for the range class
//   negate in  1  invert the result (take_till behaviour)
//   match  out 1  predicate result

module char_class_match
    import voracity_pkg::*;
(
    input  logic [7:0] data,
    input  logic [2:0] cls,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic       negate,
    output logic       match
);

    assign match = class_match(char_class_e'(cls), lo, hi, data) ^ negate;

endmodule

// File: rtl/byte_take_while.sv
// byte_take_while: streaming take_while parser. Consumes the longest prefix
// of matching bytes (up to MAX_LEN) and emits it as one token; the first
// non-matching byte stays on the input.
// Optional macro VORACITY_TAKE_TILL_EN adds the 'negate' input (take_till).
// Ports:
//   clk, rst                 clock, async active-high reset
//   mode, range_lo, range_hi class select and range bounds (sampled in IDLE)
//   negate                   predicate inversion (only with the macro)
//   in_valid/in_ready        byte input; in_ready is combinational
//   in_data, in_last         byte and end-of-frame flag
//   tok_valid/tok_ready      token output handshake
//   tok_data                 token bytes, byte 0 in [7:0], unused bytes zero
//   tok_len, tok_err         length and short-token flag
//   tok_last                 token ended by an in_last byte
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid source holds its payload until that edge.

module byte_take_while
    import voracity_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int MIN_LEN = 1,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           mode,
    input  logic [7:0]           range_lo,
    input  logic [7:0]           range_hi,
`ifdef VORACITY_TAKE_TILL_EN
    input  logic                 negate,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 tok_valid,
    input  logic                 tok_ready,
    output logic [MAX_LEN*8-1:0] tok_data,
    output logic [LEN_W-1:0]     tok_len,
    output logic                 tok_err,
    output logic                 tok_last
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    tw_state_e            state;
    tw_state_e            next_state;
    logic [2:0]           cls_q;
    logic [7:0]           lo_q;
    logic [7:0]           hi_q;
    logic                 neg_q;
    logic [LEN_W-1:0]     len_q;
    logic [MAX_LEN*8-1:0] data_q;
    logic                 last_q;
    logic                 match;

`ifdef VORACITY_TAKE_TILL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            neg_q <= negate;
        end
    end
`else
    assign neg_q = 1'b0;
`endif

    char_class_match u_match (
        .data   (in_data),
        .cls    (cls_q),
        .lo     (lo_q),
        .hi     (hi_q),
        .negate (neg_q),
        .match  (match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Any valid byte that is refused (no match, or length full) ends the
    // token without being consumed.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready = in_valid & match & (len_q < MAX_L);
                if (in_ready) begin
                    if (in_last || (len_q == MAX_L - LEN_W'(1))) begin
                        next_state = ST_EMIT;
                    end
                end else if (in_valid) begin
                    next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (tok_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls_q  <= 3'd0;
            lo_q   <= 8'd0;
            hi_q   <= 8'd0;
            len_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cls_q <= mode;
                    lo_q  <= range_lo;
                    hi_q  <= range_hi;
                end
                ST_COLLECT: begin
                    if (in_ready) begin
                        data_q[int'(len_q)*8 +: 8] <= in_data;
                        len_q  <= len_q + LEN_W'(1);
                        last_q <= in_last;
                    end
                end
                ST_EMIT: begin
                    if (tok_ready) begin
                        len_q  <= '0;
                        data_q <= '0;
                        last_q <= 1'b0;
                    end
                end
                default: begin
                    len_q <= '0;
                end
            endcase
        end
    end

    assign tok_valid = (state == ST_EMIT);
    assign tok_data  = data_q;
    assign tok_len   = len_q;
    assign tok_last  = last_q;
    assign tok_err   = (state == ST_EMIT) && (int'(len_q) < MIN_LEN);

endmodule

// File: tb/tb_byte_take_while.sv
module tb_byte_take_while;

  localparam int MAX_LEN = 4;
  localparam int MIN_LEN = 1;
  localparam int LEN_W   = 3;
  localparam int DW      = MAX_LEN * 8;
  localparam int EXP_W   = 2 + LEN_W + DW;

  logic             clk;
  logic             rst;
  logic [2:0]       mode;
  logic [7:0]       range_lo;
  logic [7:0]       range_hi;
  logic             negate;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             tok_valid;
  logic             tok_ready;
  logic [DW-1:0]    tok_data;
  logic [LEN_W-1:0] tok_len;
  logic             tok_err;
  logic             tok_last;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [7:0]  lo;
    logic [7:0]  hi;
    string       s;
    logic        fin_last;
    logic [2:0]  len;
    logic [31:0] data;
    logic        err;
    logic        last;
    int          remain;
    logic [7:0]  head;
  } vec_t;

  beat_t            src_q[$];
  logic [EXP_W-1:0] exp_q[$];
  vec_t             vecs[10];
  int               checks;
  int               errors;
  logic             acc;
  logic             hs;
  logic             seen_valid;
  logic [EXP_W-1:0] cap;

  byte_take_while #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .range_lo  (range_lo),
    .range_hi  (range_hi),
`ifdef VORACITY_TAKE_TILL_EN
    .negate    (negate),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_data  (tok_data),
    .tok_len   (tok_len),
    .tok_err   (tok_err),
    .tok_last  (tok_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EXP_W-1:0] mk(input logic last, input logic err,
                                          input logic [LEN_W-1:0] len, input logic [31:0] data);
    return {last, err, len, data};
  endfunction

  function automatic vec_t mkv(input string name, input logic [2:0] m, input logic [7:0] lo,
                               input logic [7:0] hi, input string s, input logic fin_last,
                               input logic [2:0] len, input logic [31:0] data, input logic err,
                               input logic last, input int remain, input logic [7:0] head);
    vec_t v;
    v.name = name; v.mode = m; v.lo = lo; v.hi = hi; v.s = s; v.fin_last = fin_last;
    v.len = len; v.data = data; v.err = err; v.last = last; v.remain = remain; v.head = head;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_str(input string s, input logic last_on_end);
    for (int i = 0; i < s.len(); i++) begin
      beat_t b;
      b.d = s[i];
      b.l = last_on_end && (i == s.len() - 1);
      src_q.push_back(b);
    end
  endtask

  // One clock: drive from the source queue at the falling edge, sample just
  // after, let the rising edge transfer, return at the next falling edge.
  task automatic cycle();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = src_q[0].d;
      in_last  = src_q[0].l;
    end else begin
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
    end
    #1;
    acc = in_ready;
    hs  = tok_valid & tok_ready;
    cap = {tok_last, tok_err, tok_len, tok_data};
    if (tok_valid) seen_valid = 1'b1;
    @(posedge clk);
    if (acc && (src_q.size() > 0)) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  // Collect one token; with hold>0 the token is left waiting for that many
  // cycles with tok_ready low and must stay put while no byte is taken.
  task automatic run_token(input string name, input logic [EXP_W-1:0] exp, input int hold);
    int n;
    n = 0;
    exp_q.push_back(exp);
    seen_valid = 1'b0;
    hs = 1'b0;
    tok_ready = (hold == 0);
    if (hold > 0) begin
      while (!seen_valid && n < 50) begin
        cycle();
        n++;
      end
      for (int k = 0; k < hold && seen_valid; k++) begin
        cycle();
        check({name, "_hold_valid"}, 64'(tok_valid), 64'd1);
        check({name, "_hold_tok"}, 64'(cap), 64'(exp));
        check({name, "_hold_noacc"}, 64'(acc), 64'd0);
      end
      tok_ready = 1'b1;
    end
    while (!hs && n < 50) begin
      cycle();
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no token expected a token", name);
      void'(exp_q.pop_front());
    end else begin
      check(name, 64'(cap), 64'(exp_q.pop_front()));
    end
    tok_ready = 1'b0;
  endtask

  task automatic check_remain(input string name, input int remain, input logic [7:0] head);
    check({name, "_remain"}, 64'(src_q.size()), 64'(remain));
    if (remain > 0 && src_q.size() > 0) check({name, "_head"}, 64'(src_q[0].d), 64'(head));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    mode      = 3'd0;
    range_lo  = 8'h00;
    range_hi  = 8'h00;
    negate    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    tok_ready = 1'b0;

    vecs[0] = mkv("digit_123a",   3'd1, 8'h00, 8'h00, "123a",  1'b0, 3'd3, 32'h00333231, 1'b0, 1'b0, 1, 8'h61);
    vecs[1] = mkv("alpha_7",      3'd0, 8'h00, 8'h00, "7",     1'b0, 3'd0, 32'h00000000, 1'b1, 1'b0, 1, 8'h37);
    vecs[2] = mkv("alnum_a1Z",    3'd2, 8'h00, 8'h00, "a1Z!",  1'b0, 3'd3, 32'h005A3161, 1'b0, 1'b0, 1, 8'h21);
    vecs[3] = mkv("space_last",   3'd4, 8'h00, 8'h00, " \t",   1'b1, 3'd2, 32'h00000920, 1'b0, 1'b1, 0, 8'h00);
    vecs[4] = mkv("range_ABG",    3'd5, 8'h41, 8'h46, "ABG",   1'b0, 3'd2, 32'h00004241, 1'b0, 1'b0, 1, 8'h47);
    vecs[5] = mkv("range_empty",  3'd5, 8'h50, 8'h40, "A",     1'b0, 3'd0, 32'h00000000, 1'b1, 1'b0, 1, 8'h41);
    vecs[6] = mkv("mode6",        3'd6, 8'h00, 8'hFF, "a",     1'b0, 3'd0, 32'h00000000, 1'b1, 1'b0, 1, 8'h61);
    vecs[7] = mkv("hex_F0x",      3'd3, 8'h00, 8'h00, "F0x",   1'b0, 3'd2, 32'h00003046, 1'b0, 1'b0, 1, 8'h78);
    vecs[8] = mkv("digit_9_last", 3'd1, 8'h00, 8'h00, "9",     1'b1, 3'd1, 32'h00000039, 1'b0, 1'b1, 0, 8'h00);
    vecs[9] = mkv("alpha_max",    3'd0, 8'h00, 8'h00, "AbCdE", 1'b0, 3'd4, 32'h64436241, 1'b0, 1'b0, 1, 8'h45);

    repeat (3) @(negedge clk);
    #1;
    check("reset_tok_valid", 64'(tok_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_tok", 64'({tok_last, tok_err, tok_len, tok_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      mode     = vecs[i].mode;
      range_lo = vecs[i].lo;
      range_hi = vecs[i].hi;
      src_q.delete();
      push_str(vecs[i].s, vecs[i].fin_last);
      run_token(vecs[i].name, mk(vecs[i].last, vecs[i].err, vecs[i].len, vecs[i].data), 0);
      check_remain(vecs[i].name, vecs[i].remain, vecs[i].head);
      src_q.delete();
    end

    // empty token, then a mode switch consumes the stranded byte
    mode = 3'd0;
    push_str("7", 1'b1);
    run_token("switch_alpha", mk(1'b0, 1'b1, 3'd0, 32'h0), 0);
    check_remain("switch_alpha", 1, 8'h37);
    mode = 3'd1;
    run_token("switch_digit", mk(1'b1, 1'b0, 3'd1, 32'h00000037), 0);
    check_remain("switch_digit", 0, 8'h00);

    // back-to-back tokens split at the length boundary
    mode = 3'd3;
    push_str("deadbeef", 1'b1);
    run_token("hex_dead", mk(1'b0, 1'b0, 3'd4, 32'h64616564), 0);
    check_remain("hex_dead", 4, 8'h62);
    run_token("hex_beef", mk(1'b1, 1'b0, 3'd4, 32'h66656562), 0);
    check_remain("hex_beef", 0, 8'h00);

    // downstream stall: token held, trailing byte left alone
    mode = 3'd4;
    push_str(" \t", 1'b1);
    push_str("X", 1'b0);
    run_token("space_stall", mk(1'b1, 1'b0, 3'd2, 32'h00000920), 5);
    check_remain("space_stall", 1, 8'h58);
    src_q.delete();

    // reset in the middle of a token
    mode = 3'd1;
    push_str("12", 1'b0);
    for (int n = 0; n < 20 && src_q.size() > 0; n++) cycle();
    check("midrst_consumed", 64'(src_q.size()), 64'd0);
    check("midrst_len_before", 64'(tok_len), 64'd2);
    rst = 1'b1;
    #1;
    check("midrst_tok_valid", 64'(tok_valid), 64'd0);
    check("midrst_tok", 64'({tok_last, tok_err, tok_len, tok_data}), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push_str("9", 1'b1);
    run_token("after_rst", mk(1'b1, 1'b0, 3'd1, 32'h00000039), 0);

`ifdef VORACITY_TAKE_TILL_EN
    mode   = 3'd1;
    negate = 1'b1;
    src_q.delete();
    push_str("ab1", 1'b0);
    run_token("till_digit", mk(1'b0, 1'b0, 3'd2, 32'h00006261), 0);
    check_remain("till_digit", 1, 8'h31);
    negate = 1'b0;
    src_q.delete();
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
